// File: rtl/hack_pkg.sv
// hack_pkg: shared Hack ISA widths and instruction field positions
package hack_pkg;
  localparam int WIDTH = 16;
  localparam int AW = 15;
  localparam int BIT_CI = 15;
  localparam int BIT_A = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JMP_HI = 2;
  localparam int JMP_LO = 0;
endpackage

// File: rtl/hack_alu.sv
// hack_alu: combinational Hack ALU with zero and negative flags
module hack_alu
  import hack_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] w_x, w_y, w_r;
  // zero/negate the operands, add or and them, optionally negate the result
  always_comb begin
    w_x = zx ? '0 : x;
    w_x = nx ? ~w_x : w_x;
    w_y = zy ? '0 : y;
    w_y = ny ? ~w_y : w_y;
    w_r = f ? w_x + w_y : w_x & w_y;
    out = no ? ~w_r : w_r;
    zr = out == '0;
    ng = out[WIDTH-1];
  end
endmodule

// File: rtl/hack_pc.sv
// hack_pc: program counter with reset > hold > load > inc priority
module hack_pc
  import hack_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic          hold,
  input  logic [AW-1:0] i_d,
  output logic [AW-1:0] o_q
);
  logic [AW-1:0] r_q;
  // counter register; increment wraps naturally at the top of the space
  always_ff @(posedge clk)
    if (reset) r_q <= '0;
    else if (!hold) r_q <= load ? i_d : inc ? r_q + 1'b1 : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/hack_cpu_core.sv
// hack_cpu_core: Hack CPU execution core (A/D registers, decode, jump, PC)
module hack_cpu_core
  import hack_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] inM,
  input  logic             stall,
  output logic [WIDTH-1:0] outM,
  output logic             writeM,
  output logic [AW-1:0]    addressM,
  output logic [AW-1:0]    pc
);
  logic [WIDTH-1:0] r_a, r_d, w_y;
  logic [5:0] w_comp;
  logic [2:0] w_dest, w_jmp;
  logic w_ci, w_zr, w_ng, w_take;
  // instruction decode and jump resolution from the live ALU flags
  always_comb begin
    w_ci = instruction[BIT_CI];
    w_comp = instruction[COMP_HI:COMP_LO];
    w_dest = instruction[DEST_HI:DEST_LO];
    w_jmp = instruction[JMP_HI:JMP_LO];
    w_y = instruction[BIT_A] ? inM : r_a;
    w_take = w_ci & ((w_jmp[2] & w_ng) | (w_jmp[1] & w_zr) | (w_jmp[0] & ~w_ng & ~w_zr));
    writeM = w_ci & w_dest[0] & ~stall & ~reset;
  end
  hack_alu u_alu (
    .x(r_d), .y(w_y),
    .zx(w_comp[5]), .nx(w_comp[4]), .zy(w_comp[3]), .ny(w_comp[2]), .f(w_comp[1]), .no(w_comp[0]),
    .out(outM), .zr(w_zr), .ng(w_ng)
  );
  // A and D write-back; A-instructions load the 15-bit immediate
  always_ff @(posedge clk)
    if (reset) begin
      r_a <= '0;
      r_d <= '0;
    end else if (!stall) begin
      if (!w_ci) r_a <= {1'b0, instruction[AW-1:0]};
      else if (w_dest[2]) r_a <= outM;
      if (w_ci && w_dest[1]) r_d <= outM;
    end
  hack_pc u_pc (
    .clk(clk), .reset(reset), .load(w_take), .inc(1'b1), .hold(stall),
    .i_d(r_a[AW-1:0]), .o_q(pc)
  );
  assign addressM = r_a[AW-1:0];
endmodule

// File: doc/hack_cpu_core.md
# hack_cpu_core

Execution core of the Hack CPU: holds the A and D registers and the program counter, decodes each 16-bit instruction into ALU control bits, and instantiates the existing ALU. It consumes the ALU's `out`, `zr` and `ng` for register write-back and jump resolution. It sits between instruction ROM and data RAM and executes one instruction per unstalled clock.

## Interface
- `WIDTH`, 16: data/instruction width; fixed by the Hack ISA, not to be overridden.
- `AW`, 15: address width for `pc` and `addressM`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `instruction`  in  16  current instruction from ROM at address `pc`.
- `inM`  in  16  RAM read data at `addressM`.
- `stall`  in  1  high = freeze; no state change, no memory write.
- `outM`  out  16  ALU result; RAM write data.
- `writeM`  out  1  RAM write enable, combinational.
- `addressM`  out  15  `A[14:0]`, registered value.
- `pc`  out  15  address of the next instruction to fetch.

## Operation
- A-instruction (`instruction[15]`=0): `A <= {1'b0, instruction[14:0]}`. D is unchanged, no write, `pc <= pc+1`.
- C-instruction (`instruction[15]`=1): bits 14:13 are ignored. The fields are:
  - `a`=bit12
  - ALU controls `zx,nx,zy,ny,f,no` = bits 11:6
  - dest `dA,dD,dM` = bits 5:3
  - jump `j1,j2,j3` = bits 2:0
- ALU operands: `X` = D; `Y` = `a ? inM : A`. The ALU is purely combinational; `outM` = ALU `out` at all times.
- Write-back on the clock edge:
  - `dA`: `A <= out`
  - `dD`: `D <= out`
  - `dM`: `writeM`=1 in the same cycle
- Jump: `take = (j1&ng) | (j2&zr) | (j3&~ng&~zr)`. `take` → `pc <= A_old[14:0]`, else `pc <= pc+1`.
  - `A_old` is the register value before this edge, including when `dA` is also set.
- `writeM` = `instruction[15] & dM & ~stall & ~reset`.
- `pc` is 15 bits; increment wraps 0x7FFF → 0x0000.
- Priority: `reset` > `stall` > normal execution.

## Timing
- Reset: on any edge with `reset`=1, `pc`=0, A=0, D=0. Afterwards `addressM`=0, `outM` = ALU result of the current instruction with A=D=0, and `writeM`=0.
- Reset asserted mid-program takes effect at the next edge regardless of the instruction or `stall`. The in-flight instruction's writes are discarded, and `writeM` is 0 in that cycle.
- Latency: `outM`, `writeM` and ALU flags are combinational from `instruction`, `inM`, A and D. A, D and `pc` update one edge later.
- `addressM` and `outM` for an `M` destination refer to the pre-edge A, so `AM=…` writes RAM at the old address.
- `stall`=1: A, D and `pc` hold and `writeM`=0. `outM` still tracks combinationally. `instruction` must be held stable by the fetch side.
- No handshake beyond `stall`; RAM read is assumed to be asynchronous within the cycle.

## Structure
- Shared package `hack_pkg`:
  - constants `WIDTH`=16, `AW`=15
  - instruction field positions (`BIT_CI`=15, `BIT_A`=12, `COMP_HI/LO`=11/6, `DEST_HI/LO`=5/3, `JMP_HI/LO`=2/0)
- Sub-module `hack_pc`: 15-bit counter with synchronous `reset`, `load`, `inc`, `hold`. Priority is reset > hold > load > inc.
- Instantiates the existing ALU unchanged. Decode, A/D registers and jump logic are local.

## Test plan
- Reset: `reset`=1 for 2 cycles with `instruction`=0xFFFF → `pc`=0, `addressM`=0, `writeM`=0 throughout. Reset is asserted again later mid-program at `pc`=5 → `pc`=0 and D=0 after one edge.
- A/D load: 0x0015 then 0xEC10 (D=A) then 0xE090 (D=D+A) → `addressM`=21, then D=21, then D=42. `pc` steps 1, 2, 3.
- Memory write: with A=21, D=42, apply 0xE308 (M=D) → same cycle `writeM`=1, `outM`=42, `addressM`=21. The next A-instruction gives `writeM`=0.
- Jumps, with A=100:
  - D=42, 0xE301 (D;JGT) → `pc`=100.
  - D=0, 0xE301 → `pc`=old+1.
  - 0xEA87 (0;JMP) → `pc`=100.
- Stall: `stall`=1 for 3 cycles with 0xE308 → `writeM`=0 and `pc`/A/D unchanged. On release, execution resumes with `writeM`=1.
- Wrap and A-versus-jump ordering:
  - `pc` at 0x7FFF with an A-instruction → `pc`=0x0000.
  - A=7 with an AM=M+1;JMP-style instruction (dest AM, jump 111) and `inM`=9 → RAM write at address 7 with 10, A=10, `pc`=7.
